// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared ALU control codes, alu_op/funct encodings and datapath widths
package cpu_defs;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_RTYPE = 2'b10,
      ALU_OP_RSVD  = 2'b11
   } alu_op_e;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational alu_op + funct to 4-bit ALU control code
module alu_ctrl_decode
   import cpu_defs::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control
);
   always_comb begin
      alu_control = ALU_AND;
      case (alu_op)
         ALU_OP_ADD: alu_control = ALU_ADD;
         ALU_OP_SUB: alu_control = ALU_SUB;
         ALU_OP_RTYPE: begin
            case (funct)
               FUNCT_ADD: alu_control = ALU_ADD;
               FUNCT_SUB: alu_control = ALU_SUB;
               FUNCT_AND: alu_control = ALU_AND;
               FUNCT_OR:  alu_control = ALU_OR;
               FUNCT_SLT: alu_control = ALU_SLT;
               default:   alu_control = ALU_NOP;
            endcase
         end
         default: alu_control = ALU_AND;
      endcase
   end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with ALU-control decode; ID_EX_WB_BYPASS_EN adds WB bypass
module id_ex_stage
   import cpu_defs::*;
#(
   parameter int XLEN       = cpu_defs::XLEN,
   parameter int REG_ADDR_W = cpu_defs::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [1:0]            id_alu_op,
   input  logic [5:0]            id_funct,
   input  logic                  id_alu_src,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic [XLEN-1:0]       id_rs_data,
   input  logic [XLEN-1:0]       id_rt_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  ex_valid,
   output logic [3:0]            alu_control,
   output logic [XLEN-1:0]       input1,
   output logic [XLEN-1:0]       input2,
   output logic [XLEN-1:0]       ex_rt_data,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_reg_write
);
   logic [3:0]            id_alu_control;
   logic [XLEN-1:0]       rs_val, rt_val, ex_rs_data, ex_imm;
   logic                  ex_alu_src, reg_write_q;

   alu_ctrl_decode u_decode (
      .alu_op      (id_alu_op),
      .funct       (id_funct),
      .alu_control (id_alu_control)
   );

`ifdef ID_EX_WB_BYPASS_EN
   logic [REG_ADDR_W-1:0] ex_rs, ex_rt;
   logic                  wb_hit;

   // Index 0 is hard-wired zero in the register file, so it is never bypassed.
   assign wb_hit = wb_reg_write && (wb_rd != '0);
   assign rs_val = (wb_hit && wb_rd == id_rs) ? wb_data : id_rs_data;
   assign rt_val = (wb_hit && wb_rd == id_rt) ? wb_data : id_rt_data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_reg_write, wb_rd, wb_data, id_rs, id_rt};
   assign rs_val    = id_rs_data;
   assign rt_val    = id_rt_data;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         reg_write_q <= 1'b0;
         alu_control <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_alu_src  <= 1'b0;
         ex_rd       <= '0;
`ifdef ID_EX_WB_BYPASS_EN
         ex_rs       <= '0;
         ex_rt       <= '0;
`endif
      end else if (flush) begin
         ex_valid    <= 1'b0;
         reg_write_q <= 1'b0;
         alu_control <= '0;
      end else if (stall) begin
`ifdef ID_EX_WB_BYPASS_EN
         // A held instruction must still see a result written back while it waits.
         if (wb_hit && wb_rd == ex_rs) ex_rs_data <= wb_data;
         if (wb_hit && wb_rd == ex_rt) ex_rt_data <= wb_data;
`endif
      end else begin
         ex_valid    <= id_valid;
         reg_write_q <= id_reg_write & id_valid;
         alu_control <= id_alu_control;
         ex_rs_data  <= rs_val;
         ex_rt_data  <= rt_val;
         ex_imm      <= id_imm;
         ex_alu_src  <= id_alu_src;
         ex_rd       <= id_rd;
`ifdef ID_EX_WB_BYPASS_EN
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
`endif
      end
   end

   assign input1       = ex_rs_data;
   assign input2       = ex_alu_src ? ex_imm : ex_rt_data;
   assign ex_reg_write = reg_write_q & ex_valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage (either ID_EX_WB_BYPASS_EN setting)
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, stall, flush, id_alu_src, id_reg_write, wb_reg_write;
   logic [1:0]  id_alu_op;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm, wb_data;
   logic        ex_valid, ex_reg_write;
   logic [3:0]  alu_control;
   logic [31:0] input1, input2, ex_rt_data;
   logic [4:0]  ex_rd;

   int n_checks = 0;
   int n_pass   = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
      .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .alu_control(alu_control), .input1(input1), .input2(input2),
      .ex_rt_data(ex_rt_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic src, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic rw, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm);
      id_valid = v; id_alu_op = op; id_funct = fn; id_alu_src = src;
      id_rs = rs; id_rt = rt; id_rd = rd; id_reg_write = rw;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
   endtask

   typedef struct {
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] exp;
   } dec_vec_t;

   dec_vec_t dec_tab[8] = '{
      '{2'b00, 6'b000000, 4'b0010},
      '{2'b01, 6'b000000, 4'b0110},
      '{2'b11, 6'b100000, 4'b0000},
      '{2'b10, 6'b100000, 4'b0010},
      '{2'b10, 6'b100010, 4'b0110},
      '{2'b10, 6'b100100, 4'b0000},
      '{2'b10, 6'b100101, 4'b0001},
      '{2'b10, 6'b111111, 4'b1111}
   };

   logic [31:0] exp_v;

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      set_id(1'b0, 2'b00, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
      tick(); tick();
      check("rst_valid", 32'(ex_valid), 32'd0);
      check("rst_ctrl", 32'(alu_control), 32'd0);
      check("rst_in1", input1, 32'd0);
      check("rst_in2", input2, 32'd0);
      check("rst_rd", 32'(ex_rd), 32'd0);
      check("rst_rw", 32'(ex_reg_write), 32'd0);
      reset = 1'b0;

      // R-type SLT, register operands
      set_id(1'b1, 2'b10, 6'b101010, 1'b0, 5'd5, 5'd3, 5'd4, 1'b1, 32'd5, 32'd3, 32'h0000_0077);
      tick();
      check("slt_ctrl", 32'(alu_control), 32'h7);
      check("slt_in1", input1, 32'd5);
      check("slt_in2", input2, 32'd3);
      check("slt_valid", 32'(ex_valid), 32'd1);
      check("slt_rw", 32'(ex_reg_write), 32'd1);
      check("slt_rd", 32'(ex_rd), 32'd4);

      // async reset between edges
      #3 reset = 1'b1;
      #1;
      check("arst_valid", 32'(ex_valid), 32'd0);
      check("arst_ctrl", 32'(alu_control), 32'd0);
      check("arst_in1", input1, 32'd0);
      check("arst_in2", input2, 32'd0);
      check("arst_rw", 32'(ex_reg_write), 32'd0);
      tick();
      reset = 1'b0;

      // add with immediate, then a 3-cycle stall while ID changes
      set_id(1'b1, 2'b00, 6'd0, 1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 32'd16, 32'd99, 32'hFFFF_FFFC);
      tick();
      check("addi_ctrl", 32'(alu_control), 32'h2);
      check("addi_in1", input1, 32'd16);
      check("addi_in2", input2, 32'hFFFF_FFFC);
      check("addi_rt", ex_rt_data, 32'd99);
      stall = 1'b1;
      set_id(1'b0, 2'b01, 6'd0, 1'b0, 5'd8, 5'd8, 5'd9, 1'b0, 32'd1, 32'd2, 32'd3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_ctrl", 32'(alu_control), 32'h2);
         check("stall_in2", input2, 32'hFFFF_FFFC);
         check("stall_valid", 32'(ex_valid), 32'd1);
         check("stall_rd", 32'(ex_rd), 32'd6);
      end
      stall = 1'b0;

      for (int i = 0; i < 8; i++) begin
         set_id(1'b1, dec_tab[i].op, dec_tab[i].fn, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 32'd0, 32'd0);
         tick();
         check($sformatf("dec%0d", i), 32'(alu_control), 32'(dec_tab[i].exp));
      end

      // bubble: id_valid=0 masks reg_write
      set_id(1'b0, 2'b01, 6'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 32'd0, 32'd0);
      tick();
      check("bub_valid", 32'(ex_valid), 32'd0);
      check("bub_rw", 32'(ex_reg_write), 32'd0);

      // flush and stall together: flush wins
      set_id(1'b1, 2'b00, 6'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 32'd0, 32'd0);
      tick();
      check("pre_fl_valid", 32'(ex_valid), 32'd1);
      stall = 1'b1; flush = 1'b1;
      tick();
      check("fl_valid", 32'(ex_valid), 32'd0);
      check("fl_rw", 32'(ex_reg_write), 32'd0);
      check("fl_ctrl", 32'(alu_control), 32'd0);
      stall = 1'b0; flush = 1'b0;
      set_id(1'b1, 2'b10, 6'b000111, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 32'd0, 32'd0);
      tick();
      check("bad_funct", 32'(alu_control), 32'hF);

      // WB bypass on load
      wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_DEAD;
      set_id(1'b1, 2'b00, 6'd0, 1'b0, 5'd7, 5'd7, 5'd3, 1'b1, 32'h1111, 32'h2222, 32'd0);
      tick();
`ifdef ID_EX_WB_BYPASS_EN
      exp_v = 32'h0000_DEAD;
`else
      exp_v = 32'h1111;
`endif
      check("byp_rs", input1, exp_v);
`ifdef ID_EX_WB_BYPASS_EN
      exp_v = 32'h0000_DEAD;
`else
      exp_v = 32'h2222;
`endif
      check("byp_rt", ex_rt_data, exp_v);
      wb_rd = 5'd0;
      set_id(1'b1, 2'b00, 6'd0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'h3333, 32'h4444, 32'd0);
      tick();
      check("byp_r0_rs", input1, 32'h3333);
      check("byp_r0_rt", ex_rt_data, 32'h4444);

      // WB refresh during stall
      wb_reg_write = 1'b0; wb_rd = 5'd9; wb_data = 32'h42;
      set_id(1'b1, 2'b00, 6'd0, 1'b0, 5'd2, 5'd9, 5'd3, 1'b1, 32'h10, 32'h5, 32'd0);
      tick();
      check("ref_pre", ex_rt_data, 32'h5);
      stall = 1'b1; wb_reg_write = 1'b1;
      tick();
`ifdef ID_EX_WB_BYPASS_EN
      exp_v = 32'h42;
`else
      exp_v = 32'h5;
`endif
      check("ref_rt", ex_rt_data, exp_v);
      check("ref_in2", input2, exp_v);
      check("ref_in1", input1, 32'h10);
      stall = 1'b0; wb_reg_write = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
